expr_gen: RTL and testbench
===========================

Name: expr_gen

Overview:
- Transmit-side counterpart of the expression-recognizer path: serializes a latched arithmetic expression into an ASCII byte stream, one character per accepted transfer.
- Grammar produced: digit (op digit)*, where op is '+' (0x2B) or '*' (0x2A) and digit is '0'..'9' (0x30..0x39).
- Feeds the recognizer, or any byte consumer, through a valid/ready handshake.
- Used as a stimulus source and as a formatter of operand/operator records for the downstream byte path.

Parameters:
- MAX_TERMS, 8, maximum number of digit terms per expression (1..15).

Ports:
- clk  in  1  rising-edge clock.
- clr_n  in  1  asynchronous active-low reset.
- start  in  1  request to emit one expression; sampled only in IDLE.
- terms  in  4  number of digits to emit; legal range 1..MAX_TERMS.
- digits  in  4*MAX_TERMS  BCD operands; term i occupies [4i+3:4i].
- ops  in  MAX_TERMS-1  operator between term i and term i+1 is bit i; 1 = '*', 0 = '+'.
- out_data  out  8  ASCII character.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the character.
- out_last  out  1  marks the final character of the expression.
- busy  out  1  an expression is in progress.
- done  out  1  one-cycle pulse after the last character is accepted.
- err  out  1  one-cycle pulse when a start request is rejected.

Behaviour:
- Reset (clr_n=0, asynchronous): state=IDLE, term index=0. out_data, out_valid, out_last, busy, done and err are all 0 immediately. Any stream in progress is abandoned, with no partial completion.
- All outputs are registered. out_data=0x00 whenever out_valid=0.
- States: IDLE, DIGIT, OP, DONE.
- IDLE, start=1 at edge T:
  - terms, digits and ops are latched.
  - Validation: terms must be in 1..MAX_TERMS, and each of digits[0..terms-1] must be <=9. Bits of unused terms are ignored.
  - Valid request: go to DIGIT with index=0. At T+1, busy=1, out_valid=1 and out_data=0x30+digit[0]. First-character latency is 1 cycle.
  - Invalid request: err=1 for the single cycle T+1, stay in IDLE, busy stays 0, no out_valid.
- A transfer occurs at an edge where out_valid && out_ready.
- While out_valid=1 and out_ready=0, out_data and out_last stay stable. out_valid is never withdrawn before a transfer.
- DIGIT:
  - out_data = 0x30 + digit[index].
  - out_last = (index == terms-1).
  - On transfer: if last, go to DONE; otherwise go to OP.
- OP:
  - out_data = 0x2A if ops[index]=1, else 0x2B. out_last=0.
  - On transfer: index=index+1, go to DIGIT.
- With out_ready held at 1, consecutive transfers happen on back-to-back cycles with no bubbles.
- Characters per expression: exactly 2*terms-1.
- DONE: out_valid=0, done=1, busy=1 for one cycle, then IDLE. busy reads 0 from the following cycle.
- A new start is accepted in the first IDLE cycle, so expressions can be issued at a gap of one cycle.
- start while not in IDLE (DIGIT, OP or DONE) is ignored, with no err. Input changes after latching have no effect.
- terms=1 emits a single digit with out_last=1 and no operator.

Test Plan:
- Single term: terms=1, digits[3:0]=7, out_ready=1, start at T -> T+1 shows out_data=0x37 with out_valid=1 and out_last=1; T+2 shows done=1; T+3 shows busy=0.
- Mixed operators: terms=3, digits={9,5,3} (term0=3), ops=2'b01, out_ready=1 -> 0x33, 0x2A, 0x35, 0x2B, 0x39 on 5 consecutive cycles; out_last only on 0x39. Fed into the recognizer, its out=1 after the stream ends.
- Backpressure: same stream as above with out_ready=0 for 3 cycles while 0x2A is presented -> 0x2A and out_valid held stable; no character dropped or duplicated; total transfers=5.
- Rejects: terms=0 -> err pulse and no out_valid. terms=MAX_TERMS+1 -> err. terms=2 with digit[1]=4'hA -> err, busy stays 0. terms=2 with digit[3]=4'hF (unused) -> accepted normally.
- Reset mid-stream: clr_n=0 while presenting the second character -> out_valid, busy and out_data go to 0 without waiting for clk. After release, start with terms=2, digits={1,0}, ops=0 -> 0x30, 0x2B, 0x31.
- Start while busy: pulse start with different digits during OP -> ignored; the original stream completes unchanged and err stays 0. A start in the cycle after done is accepted.

Source files
------------

// File: rtl/expr_gen_if.sv
// Byte-stream handshake between the expression generator and its consumer.
// The master drives the character, valid and last flags; the slave drives ready.
interface expr_gen_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/expr_gen.sv
// Serializes a latched digit/operator record into an ASCII expression
// "d (op d)*", one character per valid/ready transfer.
module expr_gen #(
  parameter int MAX_TERMS = 8
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   start,
  input  logic [3:0]             terms,
  input  logic [4*MAX_TERMS-1:0] digits,
  input  logic [MAX_TERMS-2:0]   ops,
  expr_gen_if.master             bus,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DIGIT = 2'd1,
    S_OP    = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state_q;
  logic [3:0]             idx_q;
  logic [3:0]             terms_q;
  logic [4*MAX_TERMS-1:0] digits_q;
  logic [MAX_TERMS-2:0]   ops_q;
  logic [7:0]             out_data_q;
  logic                   out_valid_q;
  logic                   out_last_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   err_q;

  logic [63:0]            dig_pad_s;
  logic [15:0]            ops_pad_s;
  logic [3:0]             idx_nx_s;
  logic                   xfer_s;

  function automatic logic req_ok(input logic [3:0] t, input logic [4*MAX_TERMS-1:0] d);
    logic ok;
    ok = 1'b1;
    if (t == 4'd0 || 32'(t) > MAX_TERMS) begin
      ok = 1'b0;
    end
    for (int i = 0; i < MAX_TERMS; i++) begin
      if (i < 32'(t) && d[4*i +: 4] > 4'd9) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

  function automatic logic [7:0] digit_char(input logic [3:0] nib);
    return 8'h30 + {4'h0, nib};
  endfunction

  // Zero-padded views let the running index select without width mismatches.
  assign dig_pad_s = {{(64-4*MAX_TERMS){1'b0}}, digits_q};
  assign ops_pad_s = {{(17-MAX_TERMS){1'b0}}, ops_q};
  assign idx_nx_s  = idx_q + 4'd1;
  assign xfer_s    = out_valid_q & bus.out_ready;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= S_IDLE;
      idx_q       <= 4'd0;
      terms_q     <= 4'd0;
      digits_q    <= '0;
      ops_q       <= '0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            terms_q  <= terms;
            digits_q <= digits;
            ops_q    <= ops;
            if (req_ok(terms, digits)) begin
              state_q     <= S_DIGIT;
              idx_q       <= 4'd0;
              busy_q      <= 1'b1;
              out_valid_q <= 1'b1;
              out_data_q  <= digit_char(digits[3:0]);
              out_last_q  <= (terms == 4'd1);
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_DIGIT: begin
          if (xfer_s) begin
            if (out_last_q) begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b0;
              out_data_q  <= 8'h00;
              out_last_q  <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              state_q    <= S_OP;
              out_data_q <= ops_pad_s[idx_q] ? 8'h2A : 8'h2B;
              out_last_q <= 1'b0;
            end
          end
        end
        S_OP: begin
          if (xfer_s) begin
            state_q    <= S_DIGIT;
            idx_q      <= idx_nx_s;
            out_data_q <= digit_char(dig_pad_s[{idx_nx_s, 2'b00} +: 4]);
            out_last_q <= (idx_nx_s == terms_q - 4'd1);
          end
        end
        S_DONE: begin
          // busy stays up through the done pulse and drops on return to idle
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= S_IDLE;
          idx_q       <= 4'd0;
          out_valid_q <= 1'b0;
          out_data_q  <= 8'h00;
          out_last_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_expr_gen.sv
// Randomized self-checking bench for expr_gen: a string-level reference model
// predicts each character stream, validity of requests and the done/busy timing.
module tb_expr_gen;
  localparam int MT = 8;

  logic          clk;
  logic          clr_n;
  logic          start;
  logic [3:0]    terms;
  logic [4*MT-1:0] digits;
  logic [MT-2:0] ops;
  logic          busy;
  logic          done;
  logic          err;

  expr_gen_if bus ();

  expr_gen #(.MAX_TERMS(MT)) dut (
    .clk    (clk),
    .clr_n  (clr_n),
    .start  (start),
    .terms  (terms),
    .digits (digits),
    .ops    (ops),
    .bus    (bus),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  bit         lastf_q[$];
  int  viol, valid_cycles, iters;
  bit  finished, first_valid, err_seen, done_seen, busy_in_done, busy_after;

  function automatic bit model_ok(input logic [3:0] t, input logic [4*MT-1:0] d);
    if (t < 1 || int'(t) > MT) return 1'b0;
    for (int i = 0; i < int'(t); i++) if (d[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_stream(input logic [3:0] t, input logic [4*MT-1:0] d,
                                       input logic [MT-2:0] o);
    exp_q.delete();
    for (int i = 0; i < int'(t); i++) begin
      exp_q.push_back(8'h30 + 8'(d[4*i +: 4]));
      if (i < int'(t) - 1) exp_q.push_back(o[i] ? 8'h2A : 8'h2B);
    end
  endfunction

  function automatic logic [4*MT-1:0] rand_digits();
    logic [4*MT-1:0] d;
    for (int i = 0; i < MT; i++) d[4*i +: 4] = 4'($urandom_range(0, 9));
    return d;
  endfunction

  // Starts one request from an IDLE negedge, drives ready per mode (0 always,
  // 1 random, 2 stall three cycles on '*'), collects transfers, returns at the
  // first IDLE negedge after done.
  task automatic run_stream(input logic [3:0] t, input logic [4*MT-1:0] d,
                            input logic [MT-2:0] o, input int mode, input bit poke);
    logic [7:0] prev_data;
    bit prev_valid, prev_ready, prev_last, r, poked;
    int stalls;
    got_q.delete(); lastf_q.delete();
    viol = 0; valid_cycles = 0; iters = 0; finished = 0; err_seen = 0;
    done_seen = 0; busy_in_done = 0; busy_after = 1; stalls = 0; poked = 0;
    prev_valid = 0; prev_ready = 0; prev_last = 0; prev_data = 8'h00;
    start = 1'b1; terms = t; digits = d; ops = o; bus.out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    terms = 4'($urandom); digits = {$urandom, $urandom}; ops = 7'($urandom);
    first_valid = bus.out_valid;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      iters++;
      if (err) err_seen = 1;
      if (!bus.out_valid && bus.out_data !== 8'h00) viol++;
      if (prev_valid && !prev_ready &&
          (!bus.out_valid || bus.out_data !== prev_data || bus.out_last !== prev_last)) viol++;
      if (bus.out_valid) valid_cycles++;
      case (mode)
        1: r = 1'($urandom_range(0, 1));
        2: if (bus.out_valid && bus.out_data == 8'h2A && stalls < 3) begin r = 0; stalls++; end
           else r = 1;
        default: r = 1;
      endcase
      if (poke && !poked && bus.out_valid && (bus.out_data == 8'h2A || bus.out_data == 8'h2B)) begin
        start = 1'b1; terms = 4'd2; digits = ~d; poked = 1;
      end else begin
        start = 1'b0;
      end
      bus.out_ready = r;
      prev_valid = bus.out_valid; prev_ready = r;
      prev_data = bus.out_data; prev_last = bus.out_last;
      if (bus.out_valid && r) begin
        got_q.push_back(bus.out_data);
        lastf_q.push_back(bus.out_last);
        if (bus.out_last) finished = 1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    bus.out_ready = 1'b0;
    if (finished) begin
      done_seen = done; busy_in_done = busy;
      if (err) err_seen = 1;
      if (bus.out_valid) viol++;
      @(negedge clk);
      busy_after = busy;
      if (err || done) viol++;
    end
  endtask

  task automatic check_stream(input string name);
    checks++;
    if (!finished) begin
      errors++; $display("FAIL %s timeout: got %0d chars, required %0d", name, got_q.size(), exp_q.size());
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL %s length: got %0d required %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || lastf_q[i] !== (i == exp_q.size() - 1)) begin
        errors++;
        $display("FAIL %s char[%0d]: got %h last=%0b required %h last=%0b", name, i,
                 got_q[i], lastf_q[i], exp_q[i], (i == exp_q.size() - 1));
      end
    end
    checks++;
    if (!first_valid || viol != 0 || err_seen || !done_seen || !busy_in_done || busy_after) begin
      errors++;
      $display("FAIL %s protocol: first_valid=%0b viol=%0d err=%0b done=%0b busy_done=%0b busy_after=%0b required 1 0 0 1 1 0",
               name, first_valid, viol, err_seen, done_seen, busy_in_done, busy_after);
    end
  endtask

  task automatic test_reset();
    clr_n = 1'b0; start = 1'b0; terms = 4'd0; digits = '0; ops = '0; bus.out_ready = 1'b0;
    #2;
    checks++;
    if ({bus.out_valid, bus.out_data, bus.out_last, busy, done, err} !== 13'd0) begin
      errors++; $display("FAIL reset_outputs: got v=%b d=%h l=%b busy=%b done=%b err=%b required all 0",
                         bus.out_valid, bus.out_data, bus.out_last, busy, done, err);
    end
    @(negedge clk); @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got v=%b busy=%b required 0 0", bus.out_valid, busy);
    end
  endtask

  task automatic test_single_term();
    start = 1'b1; terms = 4'd1; digits = 32'hFFFF_FFF7; ops = 7'h7F; bus.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h37 || bus.out_last !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL single_char: got v=%b d=%h l=%b busy=%b required 1 37 1 1",
                         bus.out_valid, bus.out_data, bus.out_last, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
      errors++; $display("FAIL single_done: got done=%b busy=%b v=%b d=%h required 1 1 0 00",
                         done, busy, bus.out_valid, bus.out_data);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL single_idle: got busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_mixed_ops();
    model_stream(4'd3, 32'h0000_0953, 7'b0000001);
    checks++;
    if (exp_q.size() != 5 || exp_q[1] !== 8'h2A || exp_q[3] !== 8'h2B) begin
      errors++; $display("FAIL mixed_model: got size %0d required 5", exp_q.size());
    end
    run_stream(4'd3, 32'h0000_0953, 7'b0000001, 0, 0);
    check_stream("mixed_ops");
    checks++;
    if (valid_cycles != 5 || iters != 5) begin
      errors++; $display("FAIL mixed_back_to_back: got valid_cycles=%0d cycles=%0d required 5 5", valid_cycles, iters);
    end
  endtask

  task automatic test_backpressure();
    model_stream(4'd3, 32'h0000_0953, 7'b0000001);
    run_stream(4'd3, 32'h0000_0953, 7'b0000001, 2, 0);
    check_stream("backpressure");
    checks++;
    if (iters != 8 || got_q.size() != 5) begin
      errors++; $display("FAIL backpressure_cycles: got cycles=%0d transfers=%0d required 8 5", iters, got_q.size());
    end
  endtask

  task automatic test_rejects();
    logic [3:0]      rt[3] = '{4'd0, 4'(MT + 1), 4'd2};
    logic [4*MT-1:0] rd[3] = '{32'h0000_0011, 32'h1111_1111, 32'h0000_00A3};
    for (int k = 0; k < 3; k++) begin
      start = 1'b1; terms = rt[k]; digits = rd[k]; ops = '0; bus.out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL reject_%0d: got err=%b busy=%b v=%b required 1 0 0", k, err, busy, bus.out_valid);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || busy !== 1'b0 || bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL reject_after_%0d: got err=%b busy=%b v=%b required 0 0 0", k, err, busy, bus.out_valid);
      end
    end
    bus.out_ready = 1'b0;
    model_stream(4'd2, 32'h0000_F062, 7'b1111110);
    run_stream(4'd2, 32'h0000_F062, 7'b1111110, 0, 0);
    check_stream("unused_ignored");
  endtask

  task automatic test_reset_mid();
    start = 1'b1; terms = 4'd3; digits = 32'h0000_0456; ops = 7'h03; bus.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    clr_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_data !== 8'h00 || bus.out_last !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_mid: got v=%b busy=%b d=%h l=%b done=%b required 0 0 00 0 0",
                         bus.out_valid, busy, bus.out_data, bus.out_last, done);
    end
    bus.out_ready = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    model_stream(4'd2, 32'h0000_0010, 7'd0);
    run_stream(4'd2, 32'h0000_0010, 7'd0, 0, 0);
    check_stream("after_reset");
  endtask

  task automatic test_start_while_busy();
    logic [4*MT-1:0] d;
    d = rand_digits();
    model_stream(4'd4, d, 7'b0000101);
    run_stream(4'd4, d, 7'b0000101, 1, 1);
    check_stream("start_busy");
    d = rand_digits();
    model_stream(4'd2, d, 7'b0000001);
    run_stream(4'd2, d, 7'b0000001, 0, 0);
    check_stream("start_after_done");
  endtask

  task automatic test_random();
    logic [3:0] t;
    logic [4*MT-1:0] d;
    logic [MT-2:0] o;
    for (int n = 0; n < 30; n++) begin
      t = 4'($urandom_range(0, MT + 1));
      d = rand_digits();
      if ($urandom_range(0, 4) == 0) d[4*$urandom_range(0, MT-1) +: 4] = 4'($urandom_range(10, 15));
      o = 7'($urandom);
      if (model_ok(t, d)) begin
        model_stream(t, d, o);
        run_stream(t, d, o, 1, 0);
        check_stream($sformatf("random_%0d", n));
      end else begin
        start = 1'b1; terms = t; digits = d; ops = o;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
          errors++; $display("FAIL random_reject_%0d: got err=%b v=%b busy=%b required 1 0 0", n, err, bus.out_valid, busy);
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_term();
    test_mixed_ops();
    test_backpressure();
    test_rejects();
    test_reset_mid();
    test_start_while_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
